// File: rtl/add_mul_seq_pkg.sv
// Shared types and constants for the sequential add/multiply unit.
package add_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/add_mul_step.sv
// Combinational datapath: one shift-add multiply step plus the operand adder.
module add_mul_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic               mbit_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH:0]     sum_o
);

  assign acc_o = acc_i + (mbit_i ? mcand_i : '0);
  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/add_mul_seq_unit.sv
// Sequential unsigned add (1 cycle) / shift-add multiply (WIDTH cycles) with valid/ready handshakes.
module add_mul_seq_unit
  import add_mul_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               op_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               op_q;
  logic [CW-1:0]      cnt_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     sum_d;

  add_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mbit_i  (mplier_q[0]),
    .a_i     (a),
    .b_i     (b),
    .acc_o   (acc_d),
    .sum_o   (sum_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            if (op == OP_MUL) begin
              acc_q   <= '0;
              state_q <= ST_MUL;
            end else begin
              acc_q   <= {{(WIDTH-1){1'b0}}, sum_d};
              state_q <= ST_DONE;
            end
          end
        end
        // Fixed WIDTH iterations, LSB of multiplier first; zero operands do not shortcut.
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = acc_q;
  assign op_out    = op_q;

endmodule

// File: doc/add_mul_seq_unit.md
ADD_MUL_SEQ_UNIT -- requirements
Module: add_mul_seq_unit

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 op  input  1  operation select: 0 = add, 1 = multiply.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 result  output  2*WIDTH  unsigned result.
REQ-012 op_out  output  1  op of the request that produced result.

Function
REQ-013 The unit SHALL be a three-state FSM: IDLE, MUL, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A request SHALL be accepted in the cycle in_valid=1 and in_ready=1; a, b and op are captured in that cycle and ignored afterwards.
REQ-016 Add accepted in cycle t: IDLE->DONE; result = zero-extended a+b; carry-out in bit WIDTH; upper bits 0; out_valid=1 in cycle t+1.
REQ-017 Multiply accepted in cycle t: IDLE->MUL; iterative shift-add, one multiplier bit per cycle, LSB first, over exactly WIDTH cycles; MUL->DONE; out_valid=1 in cycle t+WIDTH+1; result = a*b exact in 2*WIDTH bits.
REQ-018 No early termination for zero operands; multiply latency SHALL be fixed.
REQ-019 In DONE, result and op_out SHALL hold stable until out_valid=1 and out_ready=1; then DONE->IDLE.
REQ-020 in_ready SHALL be 0 in the cycle the result is consumed; the next request is accepted no earlier than the following cycle (no bypass).
REQ-021 in_valid during MUL or DONE SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-022 Arithmetic SHALL be unsigned; no overflow is possible in the 2*WIDTH result.

Reset
REQ-023 With rst_n=0 at a clock edge: state=IDLE, result=0, op_out=0, out_valid=0, and in_ready=1 from the next cycle.
REQ-024 Reset asserted in MUL or DONE SHALL abort the operation and discard the partial or pending result.
REQ-025 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-026 Package add_mul_seq_pkg SHALL hold the FSM state enum, op encodings (OP_ADD=0, OP_MUL=1) and the WIDTH range constants.
REQ-027 Sub-module add_mul_step SHALL be the combinational datapath:
- one shift-add step: accumulator, multiplicand and multiplier bit in; next accumulator out
- plus the WIDTH-bit adder with carry
REQ-028 Counter width SHALL be clog2(WIDTH+1) bits; no other registers beyond the operands, accumulator, op and state.

Verification (WIDTH=4)
REQ-029 Add: a=9, b=8, op=0, out_ready=1 -> result=0x11, op_out=0, out_valid high exactly one cycle after accept.
REQ-030 Multiply: a=15, b=15, op=1 -> result=225 (0xE1); out_valid rises exactly 5 cycles after accept.
REQ-031 Multiply with zero: a=0, b=13 -> result=0, latency still 5 cycles.
REQ-032 Back-pressure: 6*7 with out_ready=0 for 10 cycles -> result=42 held stable; in_valid pulses ignored; IDLE one cycle after out_ready=1.
REQ-033 Reset mid-operation: rst_n=0 two cycles into multiply 11*3 -> out_valid=0, result=0, in_ready=1 after release; next add 1+2 -> result=3.
REQ-034 Random exhaustive sweep of all 256 a/b pairs in both modes against a reference model, with random in_valid and out_ready throttling.
